display_7seg: RTL and testbench

Registered 7-segment driver for a 5-bit data word protected by an even-parity bit. It checks parity, then decodes the word to a segment pattern: a hex digit, an overflow glyph, or an error glyph. It sits between the switch/serial input stage and the physical common-cathode display of the board-level design.

---
 rtl/display_pkg.sv | 31 +++
 rtl/seg_hex_decoder.sv | 14 +
 rtl/display_7seg.sv | 56 +++++
 tb/tb_display_7seg.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared glyph definitions for 7-segment display blocks.
// Glyphs are ordered A..G with A in the MSB; 1 = segment lit.
package display_pkg;

  typedef logic [6:0] glyph_t;

  localparam glyph_t GLYPH_ERR = 7'b0000001;  // "-"
  localparam glyph_t GLYPH_OVF = 7'b0110111;  // "H"
  localparam glyph_t GLYPH_OFF = 7'b0000000;  // blank

  // Hex digit glyphs, indexed by nibble value
  localparam glyph_t HEX_GLYPH [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble-to-glyph decoder, shared by display blocks.
module seg_hex_decoder
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output glyph_t     o_glyph
);

  // Table lookup of the hex glyph
  always_comb begin
    o_glyph = HEX_GLYPH[i_nibble];
  end

endmodule

// File: rtl/display_7seg.sv
// Registered 7-segment driver for a parity-protected 5-bit word.
// Shows a hex digit, "H" for values >= 16, or "-" on a parity error.
module display_7seg
  import display_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic b4,
  input  logic b5,
  input  logic b_par,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic E,
  output logic F,
  output logic G
);

  logic   w_perr;
  glyph_t w_hex_glyph;
  glyph_t w_glyph;
  glyph_t r_seg;

  seg_hex_decoder u_hex (
    .i_nibble ({b2, b3, b4, b5}),
    .o_glyph  (w_hex_glyph)
  );

  // Parity check and glyph priority: error, then overflow, then hex
  always_comb begin
    w_perr = b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b_par;
    if (w_perr) begin
      w_glyph = GLYPH_ERR;
    end else if (b1) begin
      w_glyph = GLYPH_OVF;
    end else begin
      w_glyph = w_hex_glyph;
    end
  end

  // Output register; synchronous reset blanks the display
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg <= GLYPH_OFF;
    end else begin
      r_seg <= w_glyph;
    end
  end

  assign {A, B, C, D, E, F, G} = r_seg;

endmodule

// File: tb/tb_display_7seg.sv
// Directed testbench for display_7seg.
module tb_display_7seg;

  logic clk;
  logic rst_n;
  logic b1, b2, b3, b4, b5, b_par;
  logic A, B, C, D, E, F, G;

  int n_tests;
  int n_fail;

  display_7seg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .b1    (b1),
    .b2    (b2),
    .b3    (b3),
    .b4    (b4),
    .b5    (b5),
    .b_par (b_par),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .E     (E),
    .F     (F),
    .G     (G)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] segs();
    return {A, B, C, D, E, F, G};
  endfunction

  // Independent reference: count ones for parity, hand-written glyph list
  function automatic logic [6:0] ref_glyph(input logic [4:0] v, input logic p);
    logic [5:0] all;
    all = {v, p};
    if (($countones(all) % 2) != 0) return 7'b0000001;
    if (v > 5'd15) return 7'b0110111;
    case (v[3:0])
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v, input logic p);
    @(negedge clk);
    {b1, b2, b3, b4, b5} = v;
    b_par = p;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [4:0] v, input logic p);
    drive(v, p);
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    {b1, b2, b3, b4, b5} = 5'b00000;
    b_par   = 1'b0;

    // Reset held for two edges
    step();
    step();
    check("reset", segs(), 7'b0000000);

    // Release: first edge loads "0"
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_reset_0", segs(), 7'b1111110);

    // Parity errors
    apply(5'b00000, 1'b1);
    check("perr_00000_1", segs(), 7'b0000001);
    apply(5'b11111, 1'b0);
    check("perr_11111_0", segs(), 7'b0000001);

    // Valid hex values
    apply(5'b00001, 1'b1);
    check("hex_1", segs(), 7'b0110000);
    apply(5'b01010, 1'b0);
    check("hex_A", segs(), 7'b1110111);
    apply(5'b01111, 1'b0);
    check("hex_F", segs(), 7'b1000111);

    // Overflow
    apply(5'b10000, 1'b1);
    check("ovf_10000_1", segs(), 7'b0110111);
    apply(5'b11111, 1'b1);
    check("ovf_11111_1", segs(), 7'b0110111);

    // Latency: output holds until the next edge
    apply(5'b00011, 1'b0);
    check("lat_3", segs(), 7'b1111001);
    drive(5'b00100, 1'b1);
    #1;
    check("lat_hold", segs(), 7'b1111001);
    step();
    check("lat_4", segs(), 7'b0110011);

    // Mid-operation reset for one edge
    @(negedge clk);
    rst_n = 1'b0;
    step();
    check("mid_reset", segs(), 7'b0000000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mid_reset_recover", segs(), 7'b0110011);

    // Exhaustive sweep
    for (int i = 0; i < 64; i++) begin
      logic [5:0] vec;
      vec = 6'(i);
      apply(vec[5:1], vec[0]);
      check($sformatf("sweep_%0d", i), segs(), ref_glyph(vec[5:1], vec[0]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
